// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs, stall inputs, pipeline enables and perf counters.
// The master side is the pipeline, which drives the hazard inputs; the slave side is hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_use_rs1;
  logic             ID_use_rs2;
  logic [4:0]       EX_rd;
  logic             EX_MemRead;
  logic             EX_redirect;
  logic             mem_stall;
  logic             cnt_clr;

  logic             CTRL_SELECT;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Write;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead,
    output EX_redirect, mem_stall, cnt_clr,
    input  CTRL_SELECT, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead,
    input  EX_redirect, mem_stall, cnt_clr,
    output CTRL_SELECT, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, redirect flush sequencing, memory freeze.
// Enables are combinational (same-cycle); counters update on the following clock edge.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             luh;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             stall_inc;
  logic             flush_inc;

  // x0 is hardwired to zero, so a load targeting it never produces a usable value to wait for.
  always_comb begin
    rs1_hit = hz.ID_use_rs1 && (hz.ID_rs1 == hz.EX_rd);
    rs2_hit = hz.ID_use_rs2 && (hz.ID_rs2 == hz.EX_rd);
    luh     = hz.EX_MemRead && (hz.EX_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    hz.CTRL_SELECT = 1'b1;
    hz.PC_Write    = 1'b1;
    hz.IF_ID_Write = 1'b1;
    hz.IF_ID_Flush = 1'b0;
    hz.ID_EX_Write = 1'b1;

    if (rst) begin
      // Hold the front end and keep pushing bubbles into ID/EX until reset releases.
      hz.CTRL_SELECT = 1'b0;
      hz.PC_Write    = 1'b0;
      hz.IF_ID_Write = 1'b0;
      hz.IF_ID_Flush = 1'b1;
      hz.ID_EX_Write = 1'b1;
    end else if (hz.mem_stall) begin
      // Whole pipeline frozen; a pending redirect stays in EX and is taken afterwards.
      hz.PC_Write    = 1'b0;
      hz.IF_ID_Write = 1'b0;
      hz.ID_EX_Write = 1'b0;
      stall_inc      = 1'b1;
    end else if (hz.EX_redirect) begin
      hz.IF_ID_Flush = 1'b1;
      hz.CTRL_SELECT = 1'b0;
      flush_inc      = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
        fcnt_d  = 4'd0;
      end
    end else if (state_q == FLUSH) begin
      // The ID instruction is being squashed, so a load-use match on it is irrelevant.
      hz.IF_ID_Flush = 1'b1;
      hz.CTRL_SELECT = 1'b0;
      fcnt_d         = fcnt_q - 4'd1;
      if (fcnt_q <= 4'd1) begin
        state_d = RUN;
        fcnt_d  = 4'd0;
      end
    end else if (luh) begin
      hz.PC_Write    = 1'b0;
      hz.IF_ID_Write = 1'b0;
      hz.CTRL_SELECT = 1'b0;
      stall_inc      = 1'b1;
    end
  end

  // Saturating counters; a clear wins over a coincident increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush_inc && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (flush depth 1/2/4) share stimulus and are checked
// against a squash-count reference model, plus directed tables and corner-case sequences.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(4))  bus1 ();
  hazard_ctrl_if #(.CNT_W(32)) bus2 ();
  hazard_ctrl_if #(.CNT_W(16)) bus4 ();

  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4))  u_dut1 (.clk(clk), .rst(rst), .hz(bus1));
  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_dut2 (.clk(clk), .rst(rst), .hz(bus2));
  hazard_ctrl #(.FLUSH_CYCLES(4), .CNT_W(16)) u_dut4 (.clk(clk), .rst(rst), .hz(bus4));

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       redir;
    logic       ms;
    logic       clr;
  } in_t;

  // Expected enables packed as {CTRL_SELECT, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write}.
  typedef struct {
    in_t        in;
    logic [4:0] exp;
    string      name;
  } vec_t;

  localparam logic [4:0] O_RUN   = 5'b11101;
  localparam logic [4:0] O_LUH   = 5'b00001;
  localparam logic [4:0] O_SQ    = 5'b01111;
  localparam logic [4:0] O_MSTL  = 5'b10000;
  localparam logic [4:0] O_RESET = 5'b00011;

  int     checks = 0;
  int     errors = 0;
  in_t    cur;
  int     fc[3] = '{1, 2, 4};
  int     cw[3] = '{4, 32, 16};
  int     squash[3];
  longint m_scnt[3];
  longint m_fcnt[3];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    cur = v;
    bus1.ID_rs1 = v.rs1; bus1.ID_rs2 = v.rs2; bus1.ID_use_rs1 = v.u1; bus1.ID_use_rs2 = v.u2;
    bus1.EX_rd = v.rd; bus1.EX_MemRead = v.mr; bus1.EX_redirect = v.redir;
    bus1.mem_stall = v.ms; bus1.cnt_clr = v.clr;
    bus2.ID_rs1 = v.rs1; bus2.ID_rs2 = v.rs2; bus2.ID_use_rs1 = v.u1; bus2.ID_use_rs2 = v.u2;
    bus2.EX_rd = v.rd; bus2.EX_MemRead = v.mr; bus2.EX_redirect = v.redir;
    bus2.mem_stall = v.ms; bus2.cnt_clr = v.clr;
    bus4.ID_rs1 = v.rs1; bus4.ID_rs2 = v.rs2; bus4.ID_use_rs1 = v.u1; bus4.ID_use_rs2 = v.u2;
    bus4.EX_rd = v.rd; bus4.EX_MemRead = v.mr; bus4.EX_redirect = v.redir;
    bus4.mem_stall = v.ms; bus4.cnt_clr = v.clr;
  endtask

  function automatic logic [4:0] outs(input int k);
    case (k)
      0:       return {bus1.CTRL_SELECT, bus1.PC_Write, bus1.IF_ID_Write, bus1.IF_ID_Flush, bus1.ID_EX_Write};
      1:       return {bus2.CTRL_SELECT, bus2.PC_Write, bus2.IF_ID_Write, bus2.IF_ID_Flush, bus2.ID_EX_Write};
      default: return {bus4.CTRL_SELECT, bus4.PC_Write, bus4.IF_ID_Write, bus4.IF_ID_Flush, bus4.ID_EX_Write};
    endcase
  endfunction

  function automatic longint scnt_of(input int k);
    case (k)
      0:       return longint'(bus1.stall_cnt);
      1:       return longint'(bus2.stall_cnt);
      default: return longint'(bus4.stall_cnt);
    endcase
  endfunction

  function automatic longint fcnt_of(input int k);
    case (k)
      0:       return longint'(bus1.flush_cnt);
      1:       return longint'(bus2.flush_cnt);
      default: return longint'(bus4.flush_cnt);
    endcase
  endfunction

  // Reference model: squash[k] is how many more squash-only cycles follow the current one.
  function automatic logic model_luh(input in_t v);
    return v.mr && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
  endfunction

  function automatic logic [4:0] model_out(input int k);
    if (rst)            return O_RESET;
    if (cur.ms)         return O_MSTL;
    if (cur.redir)      return O_SQ;
    if (squash[k] > 0)  return O_SQ;
    if (model_luh(cur)) return O_LUH;
    return O_RUN;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      squash[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end
  endtask

  task automatic model_step();
    longint mx;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      bit sinc = 0;
      bit finc = 0;
      mx = (longint'(1) << cw[k]) - 1;
      if (cur.ms) sinc = 1;
      else if (cur.redir) begin finc = 1; squash[k] = fc[k] - 1; end
      else if (squash[k] > 0) squash[k]--;
      else if (model_luh(cur)) sinc = 1;
      if (cur.clr) begin
        m_scnt[k] = 0; m_fcnt[k] = 0;
      end else begin
        if (sinc && m_scnt[k] < mx) m_scnt[k]++;
        if (finc && m_fcnt[k] < mx) m_fcnt[k]++;
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_out_fc%0d", fc[k]), outs(k), model_out(k));
      chk($sformatf("model_stall_cnt_fc%0d", fc[k]), scnt_of(k), m_scnt[k]);
      chk($sformatf("model_flush_cnt_fc%0d", fc[k]), fcnt_of(k), m_fcnt[k]);
    end
  endtask

  // Called just after a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    #2;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic [4:0] rd, input logic mr,
                             input logic redir, input logic ms, input logic clr);
    in_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.redir = redir; v.ms = ms; v.clr = clr;
    return v;
  endfunction

  in_t  idle;
  in_t  luh5;
  vec_t tbl[10];

  initial begin
    longint s0, f0;
    idle = mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 0);
    luh5 = mk(5'd5, 5'd2, 1, 0, 5'd5, 1, 0, 0, 0);

    tbl[0] = '{mk(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0), O_RUN,  "no_match"};
    tbl[1] = '{luh5,                                   O_LUH,  "luh_rs1"};
    tbl[2] = '{mk(5'd0, 5'd2, 1, 1, 5'd0, 1, 0, 0, 0), O_RUN,  "rd_zero"};
    tbl[3] = '{mk(5'd1, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0), O_LUH,  "luh_rs2"};
    tbl[4] = '{mk(5'd1, 5'd9, 1, 0, 5'd9, 1, 0, 0, 0), O_RUN,  "rs2_unused"};
    tbl[5] = '{mk(5'd7, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0), O_LUH,  "luh_both"};
    tbl[6] = '{mk(5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0), O_RUN,  "not_load"};
    tbl[7] = '{mk(5'd5, 5'd2, 1, 0, 5'd5, 1, 1, 0, 0), O_SQ,   "redir_over_luh"};
    tbl[8] = '{mk(5'd5, 5'd2, 1, 0, 5'd5, 1, 0, 1, 0), O_MSTL, "mstall_over_luh"};
    tbl[9] = '{mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 1, 0), O_MSTL, "mstall_over_redir"};

    // Reset state
    rst = 1'b1;
    drive(idle);
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_out", outs(0), O_RESET);
    chk("reset_stall_cnt", scnt_of(1), 0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("run_after_reset", outs(2), O_RUN);

    // Directed table on the single-cycle-flush instance
    foreach (tbl[i]) begin
      drive(tbl[i].in);
      #1;
      chk(tbl[i].name, outs(0), tbl[i].exp);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin drive(idle); cycle(); end

    // Load-use: one stalled cycle, counter 0 -> 1
    drive(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1)); cycle();
    drive(luh5); #1; chk("luh_stall", outs(1), O_LUH); cycle();
    drive(idle); #1; chk("luh_released", outs(1), O_RUN); chk("luh_stall_cnt", scnt_of(1), 1); cycle();

    // Redirect on depth-2 instance, luh in the squash cycle ignored
    f0 = fcnt_of(1);
    drive(mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0)); #1;
    chk("redir_cyc1", outs(1), O_SQ); cycle();
    drive(luh5); #1;
    chk("redir_cyc2_luh_ignored", outs(1), O_SQ); cycle();
    drive(idle); #1;
    chk("redir_done", outs(1), O_RUN); chk("redir_flush_cnt", fcnt_of(1), f0 + 1); cycle();

    // mem_stall held 3 cycles while depth-2 instance is in FLUSH with one cycle left
    drive(mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0)); cycle();
    s0 = scnt_of(1);
    for (int i = 0; i < 3; i++) begin
      drive(mk(5'd5, 5'd2, 1, 0, 5'd5, 1, 0, 1, 0)); #1;
      chk($sformatf("mstall_freeze_%0d", i), outs(1), O_MSTL); cycle();
    end
    drive(idle); #1;
    chk("mstall_flush_resumes", outs(1), O_SQ); chk("mstall_stall_cnt", scnt_of(1), s0 + 3); cycle();
    #1; chk("mstall_flush_done", outs(1), O_RUN); cycle();

    // Saturation on the 4-bit counter instance, then clear beating a coincident increment
    for (int i = 0; i < 20; i++) begin drive(luh5); cycle(); end
    #1; chk("stall_cnt_saturated", scnt_of(0), 15);
    drive(mk(5'd5, 5'd2, 1, 0, 5'd5, 1, 0, 0, 1)); cycle();
    drive(idle); #1; chk("stall_cnt_cleared", scnt_of(0), 0); cycle();

    // Async reset raised mid-FLUSH on depth-4 instance
    drive(mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0)); cycle();
    drive(idle); #1; chk("fc4_in_flush", outs(2), O_SQ); cycle();
    #2; rst = 1'b1; #1;
    chk("async_reset_out", outs(2), O_RESET);
    chk("async_reset_flush_cnt", fcnt_of(2), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(idle); #1;
    chk("after_reset_run", outs(2), O_RUN); cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_t v;
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.u1 = 1'($urandom); v.u2 = 1'($urandom);
      v.rd = 5'($urandom_range(0, 3)); v.mr = 1'($urandom);
      v.redir = ($urandom_range(0, 99) < 15);
      v.ms = ($urandom_range(0, 99) < 15);
      v.clr = ($urandom_range(0, 99) < 3);
      drive(v);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage CPU.
- Produces the CTRL_SELECT bubble select consumed by the ID/EX control-zeroing mux, plus the PC, IF/ID and ID/EX write and flush enables.
- Detects load-use hazards and EX-stage redirects (taken branch or jump), and honours an external memory stall.
- Sequences a multi-cycle post-redirect flush and keeps saturating stall and flush event counters.

Parameters:
- FLUSH_CYCLES, 1: number of cycles IF/ID and ID/EX are squashed per redirect (legal range 1..15).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_rs1  in  5  rs1 field of the instruction in ID.
- ID_rs2  in  5  rs2 field of the instruction in ID.
- ID_use_rs1  in  1  ID instruction reads rs1.
- ID_use_rs2  in  1  ID instruction reads rs2.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_MemRead  in  1  EX instruction is a load.
- EX_redirect  in  1  EX instruction redirects the PC (taken branch or jump).
- mem_stall  in  1  data/instruction memory not ready; freeze the pipeline.
- cnt_clr  in  1  synchronous clear of both counters.
- CTRL_SELECT  out  1  1 = pass ID control signals; 0 = insert bubble into ID/EX.
- PC_Write  out  1  PC register load enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- IF_ID_Flush  out  1  IF/ID register clears to NOP on the next edge.
- ID_EX_Write  out  1  ID/EX register load enable.
- stall_cnt  out  CNT_W  cycles lost to load-use or memory stalls.
- flush_cnt  out  CNT_W  number of redirects accepted.

Behaviour:
- State machine states:
  - RUN.
  - FLUSH, with a 4-bit remaining-cycle counter fcnt.
- Reset (asynchronous, while rst=1):
  - state=RUN, fcnt=0, stall_cnt=0, flush_cnt=0.
  - Outputs forced to CTRL_SELECT=0, PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Write=1, so the pipeline fills with bubbles.
- Load-use hazard: luh = EX_MemRead & (EX_rd!=0) & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
- Outputs are combinational from state and inputs. Zero-latency decisions apply in the same cycle.
- Priority, highest first:
  1. mem_stall=1:
     - PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, CTRL_SELECT=1, IF_ID_Flush=0.
     - State and fcnt frozen; stall_cnt increments.
     - A redirect is not accepted; EX holds, so EX_redirect is re-evaluated after the stall.
  2. EX_redirect=1 (in RUN or FLUSH):
     - PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, CTRL_SELECT=0, ID_EX_Write=1.
     - flush_cnt increments.
     - If FLUSH_CYCLES>1: next state=FLUSH with fcnt=FLUSH_CYCLES-1. Otherwise state stays RUN.
     - A redirect during FLUSH restarts fcnt.
  3. state=FLUSH:
     - PC_Write=1, IF_ID_Flush=1, CTRL_SELECT=0, ID_EX_Write=1.
     - luh is ignored because the ID instruction is squashed.
     - fcnt decrements; when fcnt reaches 1, next state=RUN.
  4. luh=1 in RUN:
     - PC_Write=0, IF_ID_Write=0, CTRL_SELECT=0, IF_ID_Flush=0, ID_EX_Write=1.
     - stall_cnt increments.
     - One-cycle stall only: the load advances to MEM, so luh deasserts naturally.
  5. Otherwise: all write enables=1, CTRL_SELECT=1, IF_ID_Flush=0.
- Counters:
  - Saturate at all-ones with no wrap.
  - cnt_clr takes priority over an increment in the same cycle; the next value is 0.
- EX_rd=0 never causes a stall.
- rs1 and rs2 both matching count as a single stall cycle.
- Reset asserted mid-FLUSH aborts the flush immediately. After release the block is in RUN.

Test Plan:
- Load-use: EX_MemRead=1, EX_rd=5, ID_rs1=5, ID_use_rs1=1 for one cycle → CTRL_SELECT=0, PC_Write=0, IF_ID_Write=0 for exactly that cycle; stall_cnt 0→1. Same case with EX_rd=0 → no stall.
- Redirect with FLUSH_CYCLES=2: EX_redirect pulse for one cycle → IF_ID_Flush=1 and CTRL_SELECT=0 for 2 consecutive cycles; flush_cnt=1. A luh asserted in the second cycle is ignored (PC_Write=1).
- Simultaneous: EX_redirect=1 and luh=1 → redirect response (PC_Write=1, IF_ID_Flush=1); stall_cnt unchanged.
- mem_stall held 3 cycles during FLUSH with fcnt=1 → all write enables 0, CTRL_SELECT=1, stall_cnt +3. Flush completes one cycle after mem_stall drops.
- Counter saturation and clear: preload by forcing stall_cnt to all-ones, assert luh → value stays all-ones. Assert cnt_clr with luh=1 → stall_cnt=0.
- Async reset mid-FLUSH (FLUSH_CYCLES=4, rst raised between edges) → outputs immediately at reset values. After release with idle inputs: state RUN, CTRL_SELECT=1, all enables=1.
